// File: rtl/alu_out_stage.sv
// ============================================================================
//  Module   : alu_out_stage
//  Purpose  : ALU writeback output stage: two-entry skid buffer, HI/LO
//             registers, flag filtering and optional sticky status flags.
//             Optional feature macro: ALU_STATUS_STICKY_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;
    typedef enum logic [4:0] {
        C_ADD   = 5'd0,
        C_ADD_U = 5'd1,
        C_SUB   = 5'd2,
        C_SUB_U = 5'd3,
        C_AND   = 5'd4,
        C_OR    = 5'd5,
        C_XOR   = 5'd6,
        C_NOR   = 5'd7,
        C_SLT   = 5'd8,
        C_SLTU  = 5'd9,
        C_SLL   = 5'd10,
        C_SRL   = 5'd11,
        C_SRA   = 5'd12,
        C_LUI   = 5'd13,
        C_MULT  = 5'd14,
        C_MUL_U = 5'd15,
        C_MFHI  = 5'd16,
        C_MFLO  = 5'd17,
        C_BEQ   = 5'd18,
        C_BNE   = 5'd19,
        C_BLEZ  = 5'd20,
        C_BGTZ  = 5'd21,
        C_BLTZ  = 5'd22,
        C_BGEZ  = 5'd23,
        C_NOP   = 5'd24
    } alu_sel_t;
endpackage

module alu_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_pkg::alu_sel_t     opsel,
    input  logic [WIDTH-1:0]      result,
    input  logic [WIDTH-1:0]      result_hi,
    input  logic                  branch_taken,
    input  logic                  carry,
    input  logic                  borrow,
    input  logic                  clr_sticky,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_branch,
    output logic                  out_carry,
    output logic                  out_borrow,
    output logic [WIDTH-1:0]      hi_q,
    output logic [WIDTH-1:0]      lo_q,
    output logic                  sticky_carry,
    output logic                  sticky_borrow
);
    import alu_pkg::*;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_branch;
    logic             r_out_carry;
    logic             r_out_borrow;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_branch;
    logic             r_skid_carry;
    logic             r_skid_borrow;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_consume;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_data;
    logic             w_branch;
    logic             w_carry;
    logic             w_borrow;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;
    assign w_is_mul  = (opsel == C_MULT) || (opsel == C_MUL_U);

    // MFHI/MFLO read the committed HI/LO, so a multiply accepted the cycle
    // before is already visible here without any forwarding path.
    always_comb begin
        w_data = result;
        case (opsel)
            C_MFHI:  w_data = r_hi;
            C_MFLO:  w_data = r_lo;
            default: w_data = result;
        endcase
        w_branch = branch_taken && (opsel inside {C_BEQ, C_BNE, C_BLEZ,
                                                  C_BGTZ, C_BLTZ, C_BGEZ});
        w_carry  = carry  && (opsel == C_ADD_U);
        w_borrow = borrow && (opsel == C_SUB_U);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= EMPTY;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_branch  <= 1'b0;
            r_out_carry   <= 1'b0;
            r_out_borrow  <= 1'b0;
            r_skid_data   <= '0;
            r_skid_branch <= 1'b0;
            r_skid_carry  <= 1'b0;
            r_skid_borrow <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_out_data   <= w_data;
                        r_out_branch <= w_branch;
                        r_out_carry  <= w_carry;
                        r_out_borrow <= w_borrow;
                        r_out_valid  <= 1'b1;
                        r_state      <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        r_out_data   <= w_data;
                        r_out_branch <= w_branch;
                        r_out_carry  <= w_carry;
                        r_out_borrow <= w_borrow;
                    end else if (w_accept) begin
                        // Main word is stalled; park the newcomer in the skid slot.
                        r_skid_data   <= w_data;
                        r_skid_branch <= w_branch;
                        r_skid_carry  <= w_carry;
                        r_skid_borrow <= w_borrow;
                        r_in_ready    <= 1'b0;
                        r_state       <= TWO;
                    end else if (w_consume) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_consume) begin
                        r_out_data   <= r_skid_data;
                        r_out_branch <= r_skid_branch;
                        r_out_carry  <= r_skid_carry;
                        r_out_borrow <= r_skid_borrow;
                        r_in_ready   <= 1'b1;
                        r_state      <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // HI/LO commit at input accept, regardless of downstream stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && w_is_mul) begin
            r_hi <= result_hi;
            r_lo <= result;
        end
    end

`ifdef ALU_STATUS_STICKY_EN
    logic r_sticky_carry;
    logic r_sticky_borrow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_carry  <= 1'b0;
            r_sticky_borrow <= 1'b0;
        end else begin
            if (w_accept && w_carry) begin
                r_sticky_carry <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky_carry <= 1'b0;
            end
            if (w_accept && w_borrow) begin
                r_sticky_borrow <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky_borrow <= 1'b0;
            end
        end
    end

    assign sticky_carry  = r_sticky_carry;
    assign sticky_borrow = r_sticky_borrow;
`else
    logic w_unused_clr;
    assign w_unused_clr  = clr_sticky;
    assign sticky_carry  = 1'b0;
    assign sticky_borrow = 1'b0;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_branch = r_out_branch;
    assign out_carry  = r_out_carry;
    assign out_borrow = r_out_borrow;
    assign hi_q       = r_hi;
    assign lo_q       = r_lo;

endmodule

`default_nettype wire
